// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a persistent flag register and an optional
// iterative shift-add multiplier. One operation is accepted per
// in_valid/in_ready handshake. The result is held with out_valid until
// out_ready is seen.
//
// Build option: define ALU_MUL_EN to include the multiplier, which adds the
// BUSY state, the step counter and the 2*WIDTH accumulator. Without it,
// opcode 101 completes in one cycle with result=0 and zero=1.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid / in_ready    operation handshake (A, B, sel)
//   out_valid / out_ready  result handshake
//   result, result_hi      low result / high half of MUL product (else 0)
//   carry, zero, neg, ovf  flag register; carry feeds ADC/SBC
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept, is_mul, load_single;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r_s;
  logic             c_s, v_s;

  // Single-cycle datapath, evaluated from live operands and stored carry.
  always_comb begin
    sum = '0;
    r_s = '0;
    c_s = 1'b0;
    v_s = 1'b0;
    case (sel)
      3'b000, 3'b110: begin
        sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, (sel[2] & carry)};
        r_s = sum[WIDTH-1:0];
        c_s = sum[WIDTH];
        v_s = (A[WIDTH-1] == B[WIDTH-1]) & (sum[WIDTH-1] ^ A[WIDTH-1]);
      end
      3'b001, 3'b111: begin
        // Bit WIDTH of the (WIDTH+1)-bit difference is the borrow.
        sum = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, (sel[2] & carry)};
        r_s = sum[WIDTH-1:0];
        c_s = sum[WIDTH];
        v_s = (A[WIDTH-1] ^ B[WIDTH-1]) & (sum[WIDTH-1] ^ A[WIDTH-1]);
      end
      3'b010:  r_s = A & B;
      3'b011:  r_s = A | B;
      3'b100:  r_s = A ^ B;
      default: r_s = '0;  // MUL without multiplier: result 0, zero set
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand, acc, prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               last_step;

  assign is_mul    = (sel == 3'b101);
  assign prod_nxt  = acc + (mplier[0] ? mcand : '0);
  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= prod_nxt;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign is_mul = 1'b0;
`endif

  assign in_ready    = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept      = in_valid & in_ready;
  assign load_single = accept & ~is_mul;
  assign out_valid   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_mul ? BUSY : DONE;
`ifdef ALU_MUL_EN
      BUSY: if (last_step) state_nxt = DONE;
`else
      BUSY: state_nxt = IDLE;
`endif
      DONE: begin
        if (accept)         state_nxt = is_mul ? BUSY : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result and flag register: written only on a load, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else if (load_single) begin
      result    <= r_s;
      result_hi <= '0;
      carry     <= c_s;
      zero      <= (r_s == '0);
      neg       <= r_s[WIDTH-1];
      ovf       <= v_s;
`ifdef ALU_MUL_EN
    end else if (state == BUSY && last_step) begin
      result    <= prod_nxt[WIDTH-1:0];
      result_hi <= prod_nxt[2*WIDTH-1:WIDTH];
      carry     <= |prod_nxt[2*WIDTH-1:WIDTH];
      zero      <= (prod_nxt == '0);
      neg       <= prod_nxt[WIDTH-1];
      ovf       <= 1'b0;
`endif
    end
  end

endmodule
